code_burst_streamer: RTL and testbench

//  Downstream consumer of the 2-bit parameter-derived code word produced by the

---
 rtl/code_burst_streamer.sv | 117 +++++++++++
 tb/tb_code_burst_streamer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/code_burst_streamer.sv
// Samples an upstream code word on start and streams BURST_LEN beats
// (code, code+STEP, ...) on a valid/ready interface, then pulses done_o.
module code_burst_streamer #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned STEP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] code_i,
    input  logic             start_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SEND;
                    cnt_d   = {CNT_W{1'b0}};
                    data_d  = code_i;
                    valid_d = 1'b1;
                    last_d  = (LAST_CNT == {CNT_W{1'b0}});
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // data_q always holds base + cnt*STEP, so advancing adds STEP.
                if (valid_q && ready_i) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        data_d = data_q + STEP_W;
                        last_d = ((cnt_q + CNT_W'(1)) == LAST_CNT);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_code_burst_streamer.sv
// Directed bench for code_burst_streamer: default build plus a single-beat,
// STEP=3 build. Inputs change and outputs are sampled on the falling edge.
module tb_code_burst_streamer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] code;
    logic       start, ready;
    logic [1:0] data;
    logic       valid, last, busy, done;
    logic       start1, ready1;
    logic [1:0] data1;
    logic       valid1, last1, busy1, done1;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_a [4];

    always #5 clk = ~clk;

    code_burst_streamer #(.WIDTH(2), .BURST_LEN(4), .STEP(1)) u0 (
        .clk(clk), .rst(rst), .code_i(code), .start_i(start), .ready_i(ready),
        .data_o(data), .valid_o(valid), .last_o(last), .busy_o(busy), .done_o(done)
    );

    code_burst_streamer #(.WIDTH(2), .BURST_LEN(1), .STEP(3)) u1 (
        .clk(clk), .rst(rst), .code_i(code), .start_i(start1), .ready_i(ready1),
        .data_o(data1), .valid_o(valid1), .last_o(last1), .busy_o(busy1), .done_o(done1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] d, input logic l);
        chk({tag, "_valid"}, {7'd0, valid}, 8'd1);
        chk({tag, "_data"}, {6'd0, data}, {6'd0, d});
        chk({tag, "_last"}, {7'd0, last}, {7'd0, l});
        chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
    endtask

    initial begin
        rst = 1'b1; code = 2'd0; start = 1'b0; ready = 1'b0;
        start1 = 1'b0; ready1 = 1'b0;
        #12;
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_data", {6'd0, data}, 8'd0);
        chk("rst_last", {7'd0, last}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: back-to-back burst from code 2
        exp_a = '{2'd2, 2'd3, 2'd0, 2'd1};
        code = 2'd2; start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("t1_b%0d", k), exp_a[k], (k == 3));
            chk($sformatf("t1_nodone%0d", k), {7'd0, done}, 8'd0);
            step();
        end
        chk("t1_valid_off", {7'd0, valid}, 8'd0);
        chk("t1_done", {7'd0, done}, 8'd1);
        chk("t1_busy_done", {7'd0, busy}, 8'd1);
        step();
        chk("t1_done_pulse", {7'd0, done}, 8'd0);
        chk("t1_busy_idle", {7'd0, busy}, 8'd0);

        // 2: ready toggling, each beat held until accepted
        start = 1'b1; ready = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("t2_b%0d", k), exp_a[k], (k == 3));
            ready = 1'b0;
            step();
            chk_beat($sformatf("t2_hold%0d", k), exp_a[k], (k == 3));
            ready = 1'b1;
            step();
        end
        chk("t2_valid_off", {7'd0, valid}, 8'd0);
        chk("t2_done", {7'd0, done}, 8'd1);
        step();

        // 3: code change mid-burst ignored
        exp_a = '{2'd1, 2'd2, 2'd3, 2'd0};
        code = 2'd1; start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("t3_b%0d", k), exp_a[k], (k == 3));
            code = 2'd3;
            step();
        end
        chk("t3_done", {7'd0, done}, 8'd1);
        step();

        // 4: start held high; second burst only from IDLE
        exp_a = '{2'd0, 2'd1, 2'd2, 2'd3};
        code = 2'd0; start = 1'b1; ready = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("t4_b%0d", k), exp_a[k], (k == 3));
            step();
        end
        chk("t4_done", {7'd0, done}, 8'd1);
        chk("t4_valid_done", {7'd0, valid}, 8'd0);
        step();
        chk("t4_idle_valid", {7'd0, valid}, 8'd0);
        chk("t4_idle_busy", {7'd0, busy}, 8'd0);
        chk("t4_idle_done", {7'd0, done}, 8'd0);
        step();
        start = 1'b0;
        chk_beat("t4_second_b0", 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) step();
        chk("t4_second_done", {7'd0, done}, 8'd1);
        step();

        // 5: reset mid-burst after two handshakes
        code = 2'd2; start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk_beat("t5_b2", 2'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", {7'd0, valid}, 8'd0);
        chk("t5_rst_last", {7'd0, last}, 8'd0);
        chk("t5_rst_busy", {7'd0, busy}, 8'd0);
        chk("t5_rst_done", {7'd0, done}, 8'd0);
        step();
        chk("t5_rst_done2", {7'd0, done}, 8'd0);
        rst = 1'b0;
        exp_a = '{2'd1, 2'd2, 2'd3, 2'd0};
        code = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat($sformatf("t5_new_b%0d", k), exp_a[k], (k == 3));
            step();
        end
        chk("t5_new_done", {7'd0, done}, 8'd1);
        step();

        // 6: BURST_LEN=1, STEP=3 single beat
        code = 2'd2; start1 = 1'b1; ready1 = 1'b0;
        step();
        start1 = 1'b0;
        chk("t6_valid", {7'd0, valid1}, 8'd1);
        chk("t6_data", {6'd0, data1}, 8'd2);
        chk("t6_last", {7'd0, last1}, 8'd1);
        step();
        chk("t6_hold_valid", {7'd0, valid1}, 8'd1);
        chk("t6_hold_data", {6'd0, data1}, 8'd2);
        chk("t6_hold_last", {7'd0, last1}, 8'd1);
        ready1 = 1'b1;
        step();
        chk("t6_valid_off", {7'd0, valid1}, 8'd0);
        chk("t6_last_off", {7'd0, last1}, 8'd0);
        chk("t6_done", {7'd0, done1}, 8'd1);
        chk("t6_busy", {7'd0, busy1}, 8'd1);
        step();
        chk("t6_done_pulse", {7'd0, done1}, 8'd0);
        chk("t6_busy_idle", {7'd0, busy1}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
